approx_mult_pipe: RTL

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

---
 rtl/approx_mult_pkg.sv | 12 +
 rtl/approx_mult_pipe_if.sv | 17 +
 rtl/approx_mult_core.sv | 26 ++
 rtl/approx_mult_pipe.sv | 55 +++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: parameter legality checks and compensation-position helper shared by the multiplier pipeline
package approx_mult_pkg;

    function automatic bit params_ok(input int width, input int trunc, input int stages);
        return width >= 4 && width <= 32 && trunc >= 0 && trunc <= width - 2 && stages >= 1 && stages <= 4;
    endfunction

    function automatic int comp_pos(input int width, input int trunc);
        return width + trunc - 2;
    endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// approx_mult_pipe_if: operand/result handshake bundle for the approximate multiplier pipeline
interface approx_mult_pipe_if #(parameter int WIDTH = 8);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   x;
    logic [WIDTH-1:0]   y;
    logic               in_exact;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] z;
    logic               out_exact;
    logic [31:0]        txn_count;
    modport master (output in_valid, x, y, in_exact, out_ready,
                    input  in_ready, out_valid, z, out_exact, txn_count);
    modport slave  (input  in_valid, x, y, in_exact, out_ready,
                    output in_ready, out_valid, z, out_exact, txn_count);
endinterface

// File: rtl/approx_mult_core.sv
// approx_mult_core: combinational exact or truncated-with-compensation unsigned product
module approx_mult_core
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               exact,
    output logic [2*WIDTH-1:0] p
);
    logic [2*WIDTH-1:0] full;
    logic [2*WIDTH-1:0] trunc_prod;
    logic [2*WIDTH-1:0] comp;
    assign full       = (2*WIDTH)'(x) * (2*WIDTH)'(y);
    assign trunc_prod = ((2*WIDTH)'(x >> TRUNC) * (2*WIDTH)'(y)) << TRUNC;
    // Compensation re-adds the expected weight of the dropped low x bits
    if (TRUNC >= 2) begin : g_comp
        localparam int CP = comp_pos(WIDTH, TRUNC);
        assign comp = (2*WIDTH)'(y[WIDTH-1] & x[TRUNC-1]) << CP;
    end else begin : g_nocomp
        assign comp = '0;
    end
    assign p = exact ? full : trunc_prod + comp;
endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: valid/ready pipelined approximate multiplier with output handshake counter
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int TRUNC  = 2,
    parameter int STAGES = 2
) (
    input logic            clk,
    input logic            rst_n,
    approx_mult_pipe_if.slave bus
);
    logic                             en;
    logic [2*WIDTH-1:0]               prod;
    logic [STAGES-1:0]                v;
    logic [STAGES-1:0]                e;
    logic [STAGES-1:0][2*WIDTH-1:0]   p;
    logic [31:0]                      txn_cnt;
    if (!params_ok(WIDTH, TRUNC, STAGES)) begin : g_bad_params
        $fatal(1, "approx_mult_pipe: illegal WIDTH/TRUNC/STAGES");
    end
    // Whole pipeline moves as one unit; a stalled full output freezes every stage
    assign en            = ~v[STAGES-1] | bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = v[STAGES-1];
    assign bus.z         = p[STAGES-1];
    assign bus.out_exact = e[STAGES-1];
    assign bus.txn_count = txn_cnt;
    approx_mult_core #(.WIDTH(WIDTH), .TRUNC(TRUNC)) u_core (
        .x     (bus.x),
        .y     (bus.y),
        .exact (bus.in_exact),
        .p     (prod)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            e <= '0;
            p <= '0;
        end else if (en) begin
            v[0] <= bus.in_valid;
            e[0] <= bus.in_exact;
            p[0] <= prod;
            for (int i = 1; i < STAGES; i++) begin
                v[i] <= v[i-1];
                e[i] <= e[i-1];
                p[i] <= p[i-1];
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) txn_cnt <= '0;
        else if (v[STAGES-1] & bus.out_ready) txn_cnt <= txn_cnt + 32'd1;
    end
endmodule
